// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch engine.
// Holds the fetch FSM state encoding and the byte-counter width helper.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FS_IDLE   = 2'd0,
      FS_REQ    = 2'd1,
      FS_STREAM = 2'd2,
      FS_VALID  = 2'd3
   } fetch_state_e;

   // A single-byte instruction still needs a 1-bit counter to stay a legal vector.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory, control and decoder-side signals of the fetch engine in one bundle.
// The fetch unit is the master; the memory/decoder environment is the slave.
interface fetch_unit_if #(
   parameter int DataWidth  = 8,
   parameter int AddrWidth  = 8,
   parameter int InstrBytes = 2
);
   localparam int IrWidth = DataWidth * InstrBytes;

   logic                 Run;
   logic                 Redirect;
   logic [AddrWidth-1:0] RedirectAddr;

   logic [AddrWidth-1:0] MemAddr;
   logic                 MemRd;
   logic [DataWidth-1:0] MemDIn;

   logic [IrWidth-1:0]   IrOut;
   logic                 IrValid;
   logic                 IrReady;
   logic [AddrWidth-1:0] PcOut;
   logic                 Busy;

   modport master (
      input  Run, Redirect, RedirectAddr, MemDIn, IrReady,
      output MemAddr, MemRd, IrOut, IrValid, PcOut, Busy
   );

   modport slave (
      output Run, Redirect, RedirectAddr, MemDIn, IrReady,
      input  MemAddr, MemRd, IrOut, IrValid, PcOut, Busy
   );

endinterface

// File: rtl/fetch_unit_assembler.sv
// Shadow shift register and byte counter that build one instruction word.
// Earlier bytes shift toward the MSB so the first fetched byte ends up on top.
module fetch_unit_assembler
   import fetch_unit_pkg::*;
#(
   parameter int DataWidth  = 8,
   parameter int InstrBytes = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clear,
   input  logic                            shift,
   input  logic [DataWidth-1:0]            din,
   output logic [DataWidth*InstrBytes-1:0] assembled,
   output logic                            last
);
   localparam int IrWidth  = DataWidth * InstrBytes;
   localparam int CntWidth = cnt_width(InstrBytes);

   logic [IrWidth-1:0]  shadow_q, shadow_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   always_comb begin
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      if (clear) begin
         shadow_d = '0;
         cnt_d    = '0;
      end else if (shift) begin
         shadow_d = (shadow_q << DataWidth) | IrWidth'(din);
         cnt_d    = cnt_q + CntWidth'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         cnt_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
      end
   end

   // The final byte is merged straight from the memory bus, never stored.
   assign assembled = (shadow_q << DataWidth) | IrWidth'(din);
   assign last      = (cnt_q == CntWidth'(InstrBytes - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch engine: reads InstrBytes consecutive bytes, assembles them
// and offers the word to the decoder over valid/ready, with redirect and PC wrap.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int DataWidth   = 8,
   parameter int AddrWidth   = 8,
   parameter int InstrBytes  = 2,
   parameter int ResetVector = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   fetch_unit_if.master bus
);
   localparam int IrWidth = DataWidth * InstrBytes;
   localparam logic [AddrWidth-1:0] RstPc = AddrWidth'(ResetVector);

   fetch_state_e         state_q, state_d;
   logic [AddrWidth-1:0] fptr_q, fptr_d;
   logic [AddrWidth-1:0] ipc_q, ipc_d;
   logic [AddrWidth-1:0] pc_q, pc_d;
   logic [IrWidth-1:0]   ir_q, ir_d;
   logic                 ir_valid_q, ir_valid_d;

   logic                 asm_clear;
   logic                 asm_shift;
   logic                 asm_last;
   logic [IrWidth-1:0]   assembled;

   fetch_unit_assembler #(
      .DataWidth (DataWidth),
      .InstrBytes(InstrBytes)
   ) u_assembler (
      .clk      (Clk),
      .rst_n    (Reset),
      .clear    (asm_clear),
      .shift    (asm_shift),
      .din      (bus.MemDIn),
      .assembled(assembled),
      .last     (asm_last)
   );

   always_comb begin
      state_d    = state_q;
      fptr_d     = fptr_q;
      ipc_d      = ipc_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      asm_clear  = 1'b0;
      asm_shift  = 1'b0;

      case (state_q)
         FS_IDLE: begin
            if (bus.Run) state_d = FS_REQ;
         end
         FS_REQ: begin
            ipc_d     = fptr_q;
            fptr_d    = fptr_q + AddrWidth'(1);
            asm_clear = 1'b1;
            state_d   = FS_STREAM;
         end
         FS_STREAM: begin
            if (!asm_last) begin
               asm_shift = 1'b1;
               fptr_d    = fptr_q + AddrWidth'(1);
            end else begin
               ir_d       = assembled;
               pc_d       = ipc_q;
               ir_valid_d = 1'b1;
               state_d    = FS_VALID;
            end
         end
         FS_VALID: begin
            if (bus.IrReady) begin
               ir_valid_d = 1'b0;
               state_d    = bus.Run ? FS_REQ : FS_IDLE;
            end
         end
         default: state_d = FS_IDLE;
      endcase

      // Redirect overrides everything, including a handshake in the same cycle.
      if (bus.Redirect) begin
         fptr_d     = bus.RedirectAddr;
         ipc_d      = ipc_q;
         pc_d       = pc_q;
         ir_d       = ir_q;
         ir_valid_d = 1'b0;
         asm_clear  = 1'b1;
         asm_shift  = 1'b0;
         state_d    = bus.Run ? FS_REQ : FS_IDLE;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= FS_IDLE;
         fptr_q     <= RstPc;
         ipc_q      <= RstPc;
         pc_q       <= RstPc;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fptr_q     <= fptr_d;
         ipc_q      <= ipc_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign bus.MemAddr = fptr_q;
   assign bus.MemRd   = (state_q == FS_REQ) || ((state_q == FS_STREAM) && !asm_last);
   assign bus.IrOut   = ir_q;
   assign bus.IrValid = ir_valid_q;
   assign bus.PcOut   = pc_q;
   assign bus.Busy    = (state_q != FS_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected instruction stream is queued from a
// byte-array memory model; a negedge monitor checks every presented instruction.
module tb_fetch_unit;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int IB = 2;
   localparam int RV = 0;
   localparam int IW = DW * IB;

   typedef struct {
      logic [AW-1:0] pc;
      logic [IW-1:0] ir;
   } exp_t;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;

   fetch_unit_if #(.DataWidth(DW), .AddrWidth(AW), .InstrBytes(IB)) bus ();

   fetch_unit #(
      .DataWidth  (DW),
      .AddrWidth  (AW),
      .InstrBytes (IB),
      .ResetVector(RV)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus.master)
   );

   always #5 Clk = ~Clk;

   // Byte-wide synchronous-read memory.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] mem_dout = '0;
   always @(posedge Clk) if (bus.MemRd) mem_dout <= mem[bus.MemAddr];
   assign bus.MemDIn = mem_dout;

   int errors = 0;
   int checks = 0;
   int hs_count = 0;
   exp_t exp_q[$];
   logic [AW-1:0] push_pc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: an instruction is the IB bytes at pc..pc+IB-1 (mod 2**AW), first byte on top.
   function automatic logic [IW-1:0] ref_instr(input logic [AW-1:0] pc);
      logic [IW-1:0] r;
      r = '0;
      for (int b = 0; b < IB; b++) begin
         logic [AW-1:0] a;
         a = pc + AW'(b);
         r = (r << DW) | IW'(mem[a]);
      end
      return r;
   endfunction

   task automatic top_up();
      while (exp_q.size() < 16) begin
         exp_q.push_back('{pc: push_pc, ir: ref_instr(push_pc)});
         push_pc = push_pc + AW'(IB);
      end
   endtask

   task automatic restart(input logic [AW-1:0] addr);
      exp_q.delete();
      push_pc = addr;
      top_up();
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!bus.IrValid && n < 50) begin
         step();
         n++;
      end
      check(name, bus.IrValid, 1'b1);
   endtask

   // Monitor: every cycle an instruction is offered it must match the queue head.
   always @(negedge Clk) begin
      if (Reset && bus.IrValid) begin
         check("memrd_in_valid", bus.MemRd, 1'b0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got pc=%0h with no expected entry", bus.PcOut);
         end else begin
            check("sb_irout", bus.IrOut, exp_q[0].ir);
            check("sb_pcout", bus.PcOut, exp_q[0].pc);
            if (bus.IrReady) begin
               $display("xfer pc=%02h ir=%04h", bus.PcOut, bus.IrOut);
               void'(exp_q.pop_front());
               hs_count++;
            end
         end
      end
   end

   initial begin
      repeat (20000) @(posedge Clk);
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic redir;
      logic [AW-1:0] raddr;

      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      mem[8'h00] = 8'h12;
      mem[8'h01] = 8'h34;
      mem[8'h40] = 8'h5A;
      mem[8'h41] = 8'hC3;
      mem[8'hFF] = 8'hAB;
      bus.Run = 1'b0;
      bus.IrReady = 1'b0;
      bus.Redirect = 1'b0;
      bus.RedirectAddr = '0;

      // Reset values
      #2;
      check("rst_irvalid", bus.IrValid, 1'b0);
      check("rst_memrd", bus.MemRd, 1'b0);
      check("rst_pcout", bus.PcOut, AW'(RV));
      check("rst_memaddr", bus.MemAddr, AW'(RV));
      check("rst_irout", bus.IrOut, '0);
      check("rst_busy", bus.Busy, 1'b0);
      #10 Reset = 1'b1;
      restart(AW'(RV));
      step();

      // First fetch: one IDLE->REQ edge plus IB+1 cycles
      bus.Run = 1'b1;
      bus.IrReady = 1'b1;
      n = 0;
      do begin step(); n++; end while (!bus.IrValid && n < 20);
      check("first_latency", n, IB + 2);
      check("t1_irout", bus.IrOut, 16'h1234);
      check("t1_pcout", bus.PcOut, 8'h00);

      // Steady-state throughput
      n = 0;
      do begin step(); n++; end while (!bus.IrValid && n < 20);
      check("throughput", n, IB + 2);

      // Back-pressure: instruction held, no reads
      bus.IrReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", bus.IrValid, 1'b1);
         check("bp_memrd", bus.MemRd, 1'b0);
         check("bp_pcout", bus.PcOut, 8'h02);
      end
      bus.IrReady = 1'b1;

      // Redirect during STREAM drops the partial fetch
      step();
      step();
      bus.Redirect = 1'b1;
      bus.RedirectAddr = 8'h40;
      step();
      bus.Redirect = 1'b0;
      restart(8'h40);
      wait_valid("redir_valid");
      check("redir_irout", bus.IrOut, 16'h5AC3);
      check("redir_pcout", bus.PcOut, 8'h40);

      // Redirect to the top of memory in the same cycle as a handshake: wrap
      mem[8'h00] = 8'hCD;
      bus.Redirect = 1'b1;
      bus.RedirectAddr = 8'hFF;
      step();
      bus.Redirect = 1'b0;
      restart(8'hFF);
      wait_valid("wrap_valid");
      check("wrap_irout", bus.IrOut, 16'hABCD);
      check("wrap_pcout", bus.PcOut, 8'hFF);
      step();
      wait_valid("wrap_next_valid");
      check("wrap_next_pcout", bus.PcOut, 8'h01);

      // Asynchronous reset in the middle of STREAM
      step();
      step();
      #2 Reset = 1'b0;
      #1;
      check("async_irvalid", bus.IrValid, 1'b0);
      check("async_memrd", bus.MemRd, 1'b0);
      check("async_pcout", bus.PcOut, AW'(RV));
      check("async_busy", bus.Busy, 1'b0);
      restart(AW'(RV));
      step();
      Reset = 1'b1;
      wait_valid("rst_restart_valid");
      check("rst_restart_pcout", bus.PcOut, AW'(RV));
      check("rst_restart_irout", bus.IrOut, 16'hCD34);

      // Randomized run with stalls, Run toggling and redirects
      for (int i = 0; i < 1500; i++) begin
         redir = 1'b0;
         bus.Run = ($urandom_range(0, 9) != 0);
         bus.IrReady = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) begin
            raddr = AW'($urandom);
            bus.Redirect = 1'b1;
            bus.RedirectAddr = raddr;
            redir = 1'b1;
         end
         step();
         if (redir) begin
            bus.Redirect = 1'b0;
            restart(raddr);
         end
         top_up();
      end
      check("enough_handshakes", (hs_count >= 100), 1'b1);

      // Run=0: finish the current instruction, then settle in IDLE
      bus.Run = 1'b0;
      bus.IrReady = 1'b1;
      n = 0;
      while (bus.Busy && n < 40) begin step(); n++; end
      repeat (3) step();
      check("stop_busy", bus.Busy, 1'b0);
      check("stop_memrd", bus.MemRd, 1'b0);
      check("stop_irvalid", bus.IrValid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
